// File: rtl/duty_pwm_gen.sv
// Complementary PWM generator with a fixed period, a period-boundary duty shadow and a
// programmable dead time around every switching edge. Stop requests drain the current period.
module duty_pwm_gen #(
  parameter int PERIOD = 500,
  parameter int DEAD   = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        en,
  input  logic [11:0] l_adj,
  output logic        pwm_hi,
  output logic        pwm_lo,
  output logic        period_start,
  output logic [11:0] duty_applied,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [11:0] PER     = 12'(PERIOD);
  localparam logic [11:0] PER_M1  = 12'(PERIOD - 1);
  localparam logic [3:0]  DT_INIT = (DEAD == 0) ? 4'd0 : 4'(DEAD - 1);
  localparam bit          NO_DT   = (DEAD == 0);

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] shadow_q, shadow_d;
  logic [3:0]  dt_q, dt_d;
  logic        prev_q, prev_d;
  logic        hi_q, hi_d;
  logic        lo_q, lo_d;
  logic        ps_q, ps_d;

  logic [11:0] dclamp;
  logic        raw, wrap;

  assign dclamp = (l_adj > PER) ? PER : l_adj;
  assign raw    = (cnt_q < shadow_q);
  assign wrap   = (cnt_q == PER_M1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    dt_d     = dt_q;
    prev_d   = prev_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        hi_d   = 1'b0;
        lo_d   = 1'b0;
        prev_d = 1'b0;
        dt_d   = '0;
        if (en) begin
          state_d  = RUN;
          shadow_d = dclamp;
          dt_d     = DT_INIT;
        end
      end
      default: begin
        cnt_d  = wrap ? '0 : cnt_q + 12'd1;
        prev_d = raw;
        if (state_q == RUN && wrap) shadow_d = dclamp;
        // prev_q starts at 0 on entry, so a nonzero duty sees a rising edge at cnt 0
        if (NO_DT) begin
          hi_d = raw;
          lo_d = ~raw;
        end else if (raw != prev_q) begin
          hi_d = 1'b0;
          lo_d = 1'b0;
          dt_d = DT_INIT;
        end else if (dt_q != 4'd0) begin
          hi_d = 1'b0;
          lo_d = 1'b0;
          dt_d = dt_q - 4'd1;
        end else begin
          hi_d = raw;
          lo_d = ~raw;
        end
        if (state_q == RUN) begin
          if (!en) state_d = DRAIN;
        end else if (en) begin
          state_d = RUN;
        end else if (wrap) begin
          state_d = IDLE;
          cnt_d   = '0;
          hi_d    = 1'b0;
          lo_d    = 1'b0;
          prev_d  = 1'b0;
          dt_d    = '0;
        end
      end
    endcase
    ps_d = (state_d == RUN) && (cnt_d == 12'd0);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      dt_q     <= '0;
      prev_q   <= 1'b0;
      hi_q     <= 1'b0;
      lo_q     <= 1'b0;
      ps_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      dt_q     <= dt_d;
      prev_q   <= prev_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      ps_q     <= ps_d;
    end
  end

  assign pwm_hi       = hi_q;
  assign pwm_lo       = lo_q;
  assign period_start = ps_q;
  assign duty_applied = shadow_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_duty_pwm_gen.sv
// Directed bench for duty_pwm_gen (PERIOD=500, DEAD=4): widths, clamp, shadow timing,
// short pulses, drain/stop, and mid-period reset.
module tb_duty_pwm_gen;

  logic        clk, nrst, en;
  logic [11:0] l_adj;
  logic        pwm_hi, pwm_lo, period_start, busy;
  logic [11:0] duty_applied;

  int n_cmp = 0;
  int n_bad = 0;

  duty_pwm_gen #(.PERIOD(500), .DEAD(4)) dut (
    .clk(clk), .nrst(nrst), .en(en), .l_adj(l_adj),
    .pwm_hi(pwm_hi), .pwm_lo(pwm_lo), .period_start(period_start),
    .duty_applied(duty_applied), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n edges; counts hi/lo/period_start/both-high cycles and the first tick with hi set
  task automatic run(input int n, output int nh, output int nl, output int np,
                     output int nb, output int fh);
    nh = 0; nl = 0; np = 0; nb = 0; fh = -1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (pwm_hi) begin nh++; if (fh < 0) fh = i; end
      if (pwm_lo) nl++;
      if (period_start) np++;
      if (pwm_hi && pwm_lo) nb++;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; en = 1'b0; l_adj = 12'd0;
    tick(); tick();
    n_cmp++; if (pwm_hi !== 1'b0) begin n_bad++; $display("FAIL reset_hi got %b want 0", pwm_hi); end
    n_cmp++; if (pwm_lo !== 1'b0) begin n_bad++; $display("FAIL reset_lo got %b want 0", pwm_lo); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (period_start !== 1'b0) begin n_bad++; $display("FAIL reset_ps got %b want 0", period_start); end
    n_cmp++; if (duty_applied !== 12'd0) begin n_bad++; $display("FAIL reset_duty got %0d want 0", duty_applied); end
  endtask

  task automatic test_basic();
    int nh, nl, np, nb, fh;
    nrst = 1'b1; en = 1'b1; l_adj = 12'd100;
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL start_busy got %b want 1", busy); end
    n_cmp++; if (period_start !== 1'b1) begin n_bad++; $display("FAIL start_ps got %b want 1", period_start); end
    n_cmp++; if (duty_applied !== 12'd100) begin n_bad++; $display("FAIL start_duty got %0d want 100", duty_applied); end
    n_cmp++; if ({pwm_hi, pwm_lo} !== 2'b00) begin n_bad++; $display("FAIL start_out got %b want 00", {pwm_hi, pwm_lo}); end
    for (int p = 0; p < 2; p++) begin
      run(500, nh, nl, np, nb, fh);
      n_cmp++; if (nh != 96) begin n_bad++; $display("FAIL basic_hi_w p%0d got %0d want 96", p, nh); end
      n_cmp++; if (nl != 396) begin n_bad++; $display("FAIL basic_lo_w p%0d got %0d want 396", p, nl); end
      n_cmp++; if (fh != 5) begin n_bad++; $display("FAIL basic_first_hi p%0d got %0d want 5", p, fh); end
      n_cmp++; if (np != 1 || period_start !== 1'b1) begin n_bad++; $display("FAIL basic_ps p%0d got %0d/%b want 1/1", p, np, period_start); end
      n_cmp++; if (nb != 0) begin n_bad++; $display("FAIL basic_overlap p%0d got %0d want 0", p, nb); end
    end
  endtask

  task automatic test_change();
    int nh, nl, np, nb, fh;
    nh = 0;
    for (int i = 0; i < 500; i++) begin
      if (i == 200) l_adj = 12'd250;
      tick();
      if (pwm_hi) nh++;
      if (i == 498) begin
        n_cmp++; if (duty_applied !== 12'd100) begin n_bad++; $display("FAIL chg_duty_pre got %0d want 100", duty_applied); end
      end
    end
    n_cmp++; if (nh != 96) begin n_bad++; $display("FAIL chg_cur_hi got %0d want 96", nh); end
    n_cmp++; if (duty_applied !== 12'd250) begin n_bad++; $display("FAIL chg_duty got %0d want 250", duty_applied); end
    run(500, nh, nl, np, nb, fh);
    n_cmp++; if (nh != 246) begin n_bad++; $display("FAIL chg_next_hi got %0d want 246", nh); end
    n_cmp++; if (nl != 246) begin n_bad++; $display("FAIL chg_next_lo got %0d want 246", nl); end
  endtask

  task automatic test_short();
    int nh, nl, np, nb, fh;
    l_adj = 12'd2;
    run(500, nh, nl, np, nb, fh);
    n_cmp++; if (duty_applied !== 12'd2) begin n_bad++; $display("FAIL short_duty got %0d want 2", duty_applied); end
    run(500, nh, nl, np, nb, fh);
    n_cmp++; if (nh != 0) begin n_bad++; $display("FAIL short_hi got %0d want 0", nh); end
    n_cmp++; if (500 - nl != 6) begin n_bad++; $display("FAIL short_lo_gap got %0d want 6", 500 - nl); end
  endtask

  task automatic test_clamp();
    int nh, nl, np, nb, fh;
    l_adj = 12'd700;
    run(500, nh, nl, np, nb, fh);
    n_cmp++; if (duty_applied !== 12'd500) begin n_bad++; $display("FAIL clamp_duty got %0d want 500", duty_applied); end
    run(500, nh, nl, np, nb, fh);
    n_cmp++; if (nh != 496 || fh != 5) begin n_bad++; $display("FAIL clamp_first got %0d/%0d want 496/5", nh, fh); end
    run(500, nh, nl, np, nb, fh);
    n_cmp++; if (nh != 500 || nl != 0) begin n_bad++; $display("FAIL clamp_steady got %0d/%0d want 500/0", nh, nl); end
  endtask

  task automatic test_stop();
    int nh, nl, np, nb, fh;
    l_adj = 12'd100;
    run(500, nh, nl, np, nb, fh);
    run(300, nh, nl, np, nb, fh);
    en = 1'b0;
    run(199, nh, nl, np, nb, fh);
    n_cmp++; if (busy !== 1'b1 || pwm_lo !== 1'b1) begin n_bad++; $display("FAIL drain_run got %b%b want 11", busy, pwm_lo); end
    n_cmp++; if (np != 0) begin n_bad++; $display("FAIL drain_ps got %0d want 0", np); end
    tick();
    n_cmp++; if ({busy, pwm_hi, pwm_lo} !== 3'b000) begin n_bad++; $display("FAIL stop_idle got %b want 000", {busy, pwm_hi, pwm_lo}); end
    n_cmp++; if (duty_applied !== 12'd100) begin n_bad++; $display("FAIL stop_duty got %0d want 100", duty_applied); end
    run(20, nh, nl, np, nb, fh);
    n_cmp++; if (np + nh + nl != 0 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_quiet got %0d/%b want 0/0", np + nh + nl, busy); end
    en = 1'b1;
    tick();
    n_cmp++; if (period_start !== 1'b1) begin n_bad++; $display("FAIL restart_ps got %b want 1", period_start); end
    run(300, nh, nl, np, nb, fh);
    en = 1'b0;
    run(100, nh, nl, np, nb, fh);
    en = 1'b1;
    run(100, nh, nl, np, nb, fh);
    n_cmp++; if (np != 1 || busy !== 1'b1 || period_start !== 1'b1) begin n_bad++; $display("FAIL resume_wrap got %0d/%b want 1/1", np, busy); end
    run(500, nh, nl, np, nb, fh);
    n_cmp++; if (nh != 96 || np != 1) begin n_bad++; $display("FAIL resume_period got %0d/%0d want 96/1", nh, np); end
  endtask

  task automatic test_reset_mid();
    int nh, nl, np, nb, fh;
    run(250, nh, nl, np, nb, fh);
    n_cmp++; if (pwm_lo !== 1'b1) begin n_bad++; $display("FAIL mid_lo got %b want 1", pwm_lo); end
    nrst = 1'b0;
    tick();
    n_cmp++; if ({busy, pwm_hi, pwm_lo, period_start} !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_out got %b want 0000", {busy, pwm_hi, pwm_lo, period_start}); end
    n_cmp++; if (duty_applied !== 12'd0) begin n_bad++; $display("FAIL mid_rst_duty got %0d want 0", duty_applied); end
    nrst = 1'b1;
    tick();
    n_cmp++; if (period_start !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_restart got %b%b want 11", period_start, busy); end
    run(500, nh, nl, np, nb, fh);
    n_cmp++; if (nh != 96 || fh != 5 || nl != 396) begin n_bad++; $display("FAIL mid_period got %0d/%0d/%0d want 96/5/396", nh, fh, nl); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_change();
    test_short();
    test_clamp();
    test_stop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
